// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the CPU reset/boot/halt sequencer: state encodings, the
// output bundle that each state drives, and the r > b > h event arbitration.
package cpu_sequencer_pkg;

    localparam int CNT_W        = 16;
    localparam int BOOT_COUNT_W = 8;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_RESET = 3'd1,
        ST_BOOT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic cpu_reset;
        logic cpu_boot;
        logic cpu_halt;
    } seq_out_t;

    typedef struct packed {
        logic       taken;
        seq_state_t target;
    } seq_jump_t;

    function automatic seq_out_t state_outputs(input seq_state_t s);
        seq_out_t o;
        o = '{cpu_reset: 1'b0, cpu_boot: 1'b0, cpu_halt: 1'b0};
        case (s)
            ST_WAIT, ST_RESET: o.cpu_reset = 1'b1;
            ST_BOOT:           o.cpu_boot  = 1'b1;
            ST_HALT:           o.cpu_halt  = 1'b1;
            default:           o.cpu_reset = 1'b0;
        endcase
        return o;
    endfunction

    // Lower-priority events in the same cycle are dropped, never queued.
    // A taken jump may target the current state (restart of RESET or BOOT).
    function automatic seq_jump_t event_jump(input seq_state_t s,
                                             input logic       ev_r,
                                             input logic       ev_b,
                                             input logic       ev_h);
        seq_jump_t j;
        j.taken  = 1'b0;
        j.target = s;
        if (s == ST_RESET || s == ST_BOOT || s == ST_RUN || s == ST_HALT) begin
            if (ev_r) begin
                j.taken  = 1'b1;
                j.target = ST_RESET;
            end else if (ev_b && (s == ST_RUN || s == ST_BOOT)) begin
                j.taken  = 1'b1;
                j.target = ST_BOOT;
            end else if (ev_h && s == ST_RUN) begin
                j.taken  = 1'b1;
                j.target = ST_HALT;
            end else if (ev_h && s == ST_HALT) begin
                j.taken  = 1'b1;
                j.target = ST_RUN;
            end
        end
        return j;
    endfunction

endpackage

// File: rtl/cpu_sequencer_button_debounce.sv
// One front-panel button: 2-flop synchronizer, tick-sampled shift register,
// hysteresis level and a single-cycle pulse on the level's rising edge.
module button_debounce #(
    parameter int DEB_LEN = 10
) (
    input  logic sysclk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic rise
);

    logic [1:0]         sync;
    logic [DEB_LEN-1:0] samples;
    logic [DEB_LEN-1:0] samples_next;
    logic               level;
    logic               level_prev;

    assign samples_next = {samples[DEB_LEN-2:0], sync[1]};

    // Level only moves on a unanimous window; mixed windows hold it.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync       <= '0;
            samples    <= '0;
            level      <= 1'b0;
            level_prev <= 1'b0;
        end else begin
            sync       <= {sync[0], raw};
            level_prev <= level;
            if (tick) begin
                samples <= samples_next;
                if (&samples_next) begin
                    level <= 1'b1;
                end else if (~|samples_next) begin
                    level <= 1'b0;
                end
            end
        end
    end

    assign rise = level & ~level_prev;

endmodule

// File: rtl/cpu_sequencer.sv
// Reset/boot/halt sequencer: waits for memory, times cpu_reset and cpu_boot,
// and handles debounced reset/boot/halt button events.
//
//   state | meaning
//   WAIT  | hold CPU in reset until memory init is done
//   RESET | timed cpu_reset pulse
//   BOOT  | timed cpu_boot pulse
//   RUN   | CPU running
//   HALT  | CPU halted, waiting for resume
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int RESET_CYCLES = 40,
    parameter int BOOT_CYCLES  = 16,
    parameter int DEB_DIV      = 32768,
    parameter int DEB_LEN      = 10
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic                    button_r,
    input  logic                    button_b,
    input  logic                    button_h,
    input  logic                    mem_ready,
    output logic                    cpu_reset,
    output logic                    cpu_boot,
    output logic                    cpu_halt,
    output logic                    interrupt,
    output logic [2:0]              seq_state,
    output logic [BOOT_COUNT_W-1:0] boot_count
);

    localparam int PRE_W = $clog2(DEB_DIV);
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [1:0]       mem_sync;
    logic             ev_r;
    logic             ev_b;
    logic             ev_h;
    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    seq_out_t         outs;
    seq_jump_t        jump;

    assign tick = (pre == '0);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            pre      <= '0;
            mem_sync <= '0;
        end else begin
            pre      <= tick ? PRE_RELOAD : pre - PRE_W'(1);
            mem_sync <= {mem_sync[0], mem_ready};
        end
    end

    button_debounce #(.DEB_LEN(DEB_LEN)) u_deb_r (
        .sysclk (sysclk),
        .reset  (reset),
        .raw    (button_r),
        .tick   (tick),
        .rise   (ev_r)
    );

    button_debounce #(.DEB_LEN(DEB_LEN)) u_deb_b (
        .sysclk (sysclk),
        .reset  (reset),
        .raw    (button_b),
        .tick   (tick),
        .rise   (ev_b)
    );

    button_debounce #(.DEB_LEN(DEB_LEN)) u_deb_h (
        .sysclk (sysclk),
        .reset  (reset),
        .raw    (button_h),
        .tick   (tick),
        .rise   (ev_h)
    );

    assign jump = event_jump(state, ev_r, ev_b, ev_h);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= ST_WAIT;
            cnt        <= '0;
            outs       <= state_outputs(ST_WAIT);
            boot_count <= '0;
        end else if (jump.taken) begin
            state <= jump.target;
            cnt   <= '0;
            outs  <= state_outputs(jump.target);
        end else begin
            case (state)
                ST_WAIT: begin
                    if (mem_sync[1]) begin
                        state <= ST_RESET;
                        cnt   <= '0;
                        outs  <= state_outputs(ST_RESET);
                    end
                end
                ST_RESET: begin
                    if (cnt == RESET_LAST) begin
                        state <= ST_BOOT;
                        cnt   <= '0;
                        outs  <= state_outputs(ST_BOOT);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_BOOT: begin
                    if (cnt == BOOT_LAST) begin
                        state      <= ST_RUN;
                        cnt        <= '0;
                        outs       <= state_outputs(ST_RUN);
                        boot_count <= boot_count + BOOT_COUNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN, ST_HALT: begin
                    cnt <= '0;
                end
                default: begin
                    // Unreachable encodings fall back to the safe reset-held state.
                    state <= ST_WAIT;
                    cnt   <= '0;
                    outs  <= state_outputs(ST_WAIT);
                end
            endcase
        end
    end

    assign cpu_reset = outs.cpu_reset;
    assign cpu_boot  = outs.cpu_boot;
    assign cpu_halt  = outs.cpu_halt;
    assign interrupt = 1'b0;
    assign seq_state = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a fast debounce prescaler.
module tb_cpu_sequencer;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       button_r;
    logic       button_b;
    logic       button_h;
    logic       mem_ready;
    logic       cpu_reset;
    logic       cpu_boot;
    logic       cpu_halt;
    logic       interrupt;
    logic [2:0] seq_state;
    logic [7:0] boot_count;

    int total = 0;
    int bad   = 0;
    int lat;
    int changed;
    int timeouts;

    cpu_sequencer #(
        .RESET_CYCLES (40),
        .BOOT_CYCLES  (16),
        .DEB_DIV      (4),
        .DEB_LEN      (10)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .button_r   (button_r),
        .button_b   (button_b),
        .button_h   (button_h),
        .mem_ready  (mem_ready),
        .cpu_reset  (cpu_reset),
        .cpu_boot   (cpu_boot),
        .cpu_halt   (cpu_halt),
        .interrupt  (interrupt),
        .seq_state  (seq_state),
        .boot_count (boot_count)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold the given buttons until the state moves (or 80 cycles pass), then release.
    task automatic press(input logic r, input logic b, input logic h, output int cycles);
        logic [2:0] start;
        start    = seq_state;
        button_r = r;
        button_b = b;
        button_h = h;
        cycles   = 0;
        while (seq_state === start && cycles < 80) begin
            @(negedge sysclk);
            cycles++;
        end
        button_r = 1'b0;
        button_b = 1'b0;
        button_h = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        button_r  = 1'b0;
        button_b  = 1'b0;
        button_h  = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge sysclk);
        check("rst_state", seq_state, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_cpu_boot", cpu_boot, 0);
        check("rst_cpu_halt", cpu_halt, 0);
        check("rst_boot_count", boot_count, 0);
        check("rst_interrupt", interrupt, 0);

        // Power-on: memory ready at edge k -> RESET k+2, BOOT k+42, RUN k+58.
        reset = 1'b0;
        repeat (9) @(negedge sysclk);
        check("wait_ignores_ready", seq_state, 0);
        mem_ready = 1'b1;
        repeat (2) @(negedge sysclk);
        check("wait_sync_state", seq_state, 0);
        check("wait_sync_reset", cpu_reset, 1);
        @(negedge sysclk);
        check("po_reset_state", seq_state, 1);
        check("po_reset_out", cpu_reset, 1);
        repeat (39) @(negedge sysclk);
        check("po_reset_last", seq_state, 1);
        check("po_reset_last_out", cpu_reset, 1);
        @(negedge sysclk);
        check("po_boot_state", seq_state, 2);
        check("po_boot_reset", cpu_reset, 0);
        check("po_boot_out", cpu_boot, 1);
        repeat (15) @(negedge sysclk);
        check("po_boot_last", cpu_boot, 1);
        @(negedge sysclk);
        check("po_run_state", seq_state, 3);
        check("po_run_boot", cpu_boot, 0);
        check("po_boot_count", boot_count, 1);

        // Bounce: a 6-cycle toggle never fills a 10-sample window.
        changed = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 3 == 0) button_r = ~button_r;
            @(negedge sysclk);
            if (seq_state !== 3'd3) changed = 1;
        end
        check("bounce_no_event", changed, 0);
        button_r = 1'b1;
        lat = 0;
        while (seq_state === 3'd3 && lat < 80) begin
            @(negedge sysclk);
            lat++;
        end
        button_r = 1'b0;
        check("bounce_ev_state", seq_state, 1);
        check("bounce_latency_ok", (lat >= 30 && lat <= 44), 1);
        repeat (39) @(negedge sysclk);
        check("bounce_single_ev", seq_state, 1);
        @(negedge sysclk);
        check("bounce_boot", seq_state, 2);
        repeat (16) @(negedge sysclk);
        check("bounce_run", seq_state, 3);
        check("bounce_boot_count", boot_count, 2);

        // Halt / resume, boot ignored while halted.
        press(1'b0, 1'b0, 1'b1, lat);
        check("halt_state", seq_state, 4);
        check("halt_out", cpu_halt, 1);
        repeat (50) @(negedge sysclk);
        press(1'b0, 1'b0, 1'b1, lat);
        check("resume_state", seq_state, 3);
        check("resume_out", cpu_halt, 0);
        repeat (50) @(negedge sysclk);
        press(1'b0, 1'b0, 1'b1, lat);
        check("halt2_state", seq_state, 4);
        repeat (50) @(negedge sysclk);
        press(1'b0, 1'b1, 1'b0, lat);
        check("halt_b_ignored_lat", lat, 80);
        check("halt_b_ignored_state", seq_state, 4);
        check("halt_b_ignored_boot", cpu_boot, 0);
        repeat (50) @(negedge sysclk);
        press(1'b0, 1'b0, 1'b1, lat);
        check("resume2_state", seq_state, 3);
        repeat (50) @(negedge sysclk);

        // Simultaneous r+b from RUN: reset wins, boot waits for the full reset.
        press(1'b1, 1'b1, 1'b0, lat);
        check("simul_state", seq_state, 1);
        check("simul_boot", cpu_boot, 0);
        repeat (39) @(negedge sysclk);
        check("simul_reset_full", seq_state, 1);
        check("simul_boot_low", cpu_boot, 0);
        @(negedge sysclk);
        check("simul_boot_state", seq_state, 2);
        repeat (16) @(negedge sysclk);
        check("simul_run", seq_state, 3);
        check("simul_boot_count", boot_count, 3);
        repeat (50) @(negedge sysclk);

        // Asynchronous reset in the middle of BOOT.
        press(1'b1, 1'b0, 1'b0, lat);
        check("mid_reset_entry", seq_state, 1);
        repeat (40) @(negedge sysclk);
        check("mid_boot_entry", seq_state, 2);
        repeat (9) @(negedge sysclk);
        #2 reset = 1'b1;
        #1;
        check("mid_async_state", seq_state, 0);
        check("mid_async_reset", cpu_reset, 1);
        check("mid_async_boot", cpu_boot, 0);
        check("mid_async_count", boot_count, 0);
        @(negedge sysclk);
        reset = 1'b0;
        repeat (2) @(negedge sysclk);
        check("mid_rewait", seq_state, 0);
        @(negedge sysclk);
        check("mid_reset_again", seq_state, 1);
        repeat (40) @(negedge sysclk);
        check("mid_boot_again", seq_state, 2);
        repeat (16) @(negedge sysclk);
        check("mid_run_again", seq_state, 3);
        check("mid_count_again", boot_count, 1);
        repeat (50) @(negedge sysclk);

        // Wrap: 254 boot presses take the count from 1 to 255, one more to 0.
        timeouts = 0;
        for (int i = 0; i < 254; i++) begin
            press(1'b0, 1'b1, 1'b0, lat);
            if (lat >= 80) timeouts++;
            repeat (60) @(negedge sysclk);
        end
        check("wrap_no_timeouts", timeouts, 0);
        check("wrap_count_255", boot_count, 8'hff);
        press(1'b0, 1'b1, 1'b0, lat);
        check("wrap_last_boot", seq_state, 2);
        repeat (60) @(negedge sysclk);
        check("wrap_count_0", boot_count, 0);
        check("wrap_run", seq_state, 3);
        check("end_interrupt", interrupt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
